// File: rtl/fetch_pkg.sv
// Shared fetch constants, the buffered-entry type and the PC step helper.
// Used by pc_fetch_unit and fetch_buffer.
package fetch_pkg;

    localparam int XLEN       = 32;
    localparam int FIFO_DEPTH = 2;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_STEP       = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + INSTR_STEP;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {instr, pc} fetch results.
// Push and pop may happen in the same cycle, even when full; flush wins over both.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  fetch_entry_t i_wdata,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [FIFO_DEPTH];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_do_pop;
    logic         w_do_push;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    // A full buffer can still take a word when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_count != 2'(FIFO_DEPTH)) || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == 2'(FIFO_DEPTH));
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: PC register, one-cycle-latency memory requests, 2-entry result buffer.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky misalign flag for unaligned redirects.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic            misalign
`endif
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pending_pc;
    logic            r_pending;

    fetch_entry_t    w_head;
    fetch_entry_t    w_wdata;
    logic            w_full;
    logic            w_empty;
    logic [1:0]      w_count;
    logic [2:0]      w_load;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic            w_halt;
    logic [XLEN-1:0] w_redirect_target;

    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    // The word returning this cycle belongs to the old stream when a redirect arrives.
    assign w_push    = r_pending & ~redirect_valid;
    assign w_wdata   = '{instr: imem_rdata, pc: r_pending_pc};

    // Slots still claimed once this cycle's pop leaves; counting the pop keeps one word per cycle.
    assign w_load  = 3'(w_count) + 3'(r_pending) - 3'(w_pop);
    assign w_issue = ~reset & ~redirect_valid & ~w_halt
                   & (w_load < 3'd2) & (~w_full | w_pop);

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_pending    <= 1'b0;
            r_pending_pc <= '0;
        end else begin
            r_pending <= w_issue;
            if (w_issue) begin
                r_pending_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc <= w_redirect_target;
            end else if (w_issue) begin
                r_pc <= next_pc(r_pc);
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign          = r_misalign;
    assign w_halt            = r_misalign;
    assign w_redirect_target = redirect_pc;
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(INSTR_STEP - 32'd1);

    assign w_halt            = 1'b0;
    assign w_redirect_target = redirect_pc & ALIGN_MASK;
`endif

    fetch_buffer u_fetch_buffer (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Outputs read as zero whenever nothing is presented, including throughout reset.
    assign out_instr    = out_valid ? w_head.instr       : '0;
    assign out_pc       = out_valid ? w_head.pc          : '0;
    assign out_pc_plus4 = out_valid ? next_pc(w_head.pc) : '0;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a RESET_PC=0 instance for stream, backpressure,
// redirect and reset cases, plus a RESET_PC=FFFF_FFF8 instance for PC wrap-around.
module tb_pc_fetch_unit;

    localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign;
    logic        wr_misalign;
`endif

    logic        wr_imem_req;
    logic [31:0] wr_imem_addr;
    logic [31:0] wr_imem_rdata;
    logic        wr_out_valid;
    logic [31:0] wr_out_instr;
    logic [31:0] wr_out_pc;
    logic [31:0] wr_out_pc_plus4;
    logic        wr_redirect_valid = 1'b0;
    logic [31:0] wr_redirect_pc    = 32'h0;
    logic        wr_out_ready      = 1'b1;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign       (misalign)
`endif
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (wr_imem_req),
        .imem_addr      (wr_imem_addr),
        .imem_rdata     (wr_imem_rdata),
        .redirect_valid (wr_redirect_valid),
        .redirect_pc    (wr_redirect_pc),
        .out_valid      (wr_out_valid),
        .out_ready      (wr_out_ready),
        .out_instr      (wr_out_instr),
        .out_pc         (wr_out_pc),
        .out_pc_plus4   (wr_out_pc_plus4)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign       (wr_misalign)
`endif
    );

    // Instruction memory: word returned one cycle after the address, keyed by address.
    always @(posedge clock) begin
        imem_rdata    <= imem_addr ^ DATA_KEY;
        wr_imem_rdata <= wr_imem_addr ^ DATA_KEY;
    end

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        wvalid;
        logic [31:0] wpc;
        logic        mis;
    } sample_t;

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
    } redir_vec_t;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam int N_VEC = 3;
`else
    localparam int N_VEC = 4;
`endif

    sample_t     smp;
    logic [31:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          n_xfer = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic sb_stream(input logic [31:0] start);
        exp_q.delete();
        for (int k = 0; k < 128; k++) begin
            exp_q.push_back(start + 32'(4 * k));
        end
    endtask

    task automatic sb_check();
        logic [31:0] e;
        n_xfer++;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_extra: actual out_pc=%h required no transfer", out_pc);
        end else begin
            e = exp_q.pop_front();
            $display("xfer pc=%h instr=%h pc4=%h", out_pc, out_instr, out_pc_plus4);
            check("sb_pc", out_pc, e);
            check("sb_instr", out_instr, e ^ DATA_KEY);
            check("sb_pc4", out_pc_plus4, e + 32'd4);
        end
    endtask

    // Samples the current cycle at the falling edge, then moves to just after the next rising edge.
    task automatic step();
        @(negedge clock);
        smp.req    = imem_req;
        smp.addr   = imem_addr;
        smp.valid  = out_valid;
        smp.pc     = out_pc;
        smp.pc4    = out_pc_plus4;
        smp.wvalid = wr_out_valid;
        smp.wpc    = wr_out_pc;
`ifdef FETCH_ALIGN_CHECK_EN
        smp.mis    = misalign;
`else
        smp.mis    = 1'b0;
`endif
        if (!reset && out_valid && out_ready) begin
            sb_check();
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
        sb_stream(32'h0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        redir_vec_t  vec [N_VEC];
        logic [31:0] wrap_exp [3];
        int          x0;

        vec[0] = '{target: 32'h0000_0100, exp_pc: 32'h0000_0100, exp_pc4: 32'h0000_0104};
        vec[1] = '{target: 32'h0000_2000, exp_pc: 32'h0000_2000, exp_pc4: 32'h0000_2004};
        vec[2] = '{target: 32'hFFFF_FFFC, exp_pc: 32'hFFFF_FFFC, exp_pc4: 32'h0000_0000};
`ifndef FETCH_ALIGN_CHECK_EN
        vec[3] = '{target: 32'h0000_0103, exp_pc: 32'h0000_0100, exp_pc4: 32'h0000_0104};
`endif
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;

        reset          = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        step();
        step();
        check("rst_req", 32'(smp.req), 32'd0);
        check("rst_valid", 32'(smp.valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", smp.pc, 32'd0);
        check("rst_pc4", smp.pc4, 32'd0);
        check("rst_wrap_valid", 32'(smp.wvalid), 32'd0);
        check("rst_misalign", 32'(smp.mis), 32'd0);

        // Release: back-to-back requests, two-cycle latency, wrap instance rolls over.
        reset = 1'b0;
        sb_stream(32'h0);
        for (int c = 0; c < 8; c++) begin
            step();
            check("rel_req", 32'(smp.req), 32'd1);
            check("rel_addr", smp.addr, 32'(4 * c));
            check("rel_valid", 32'(smp.valid), (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2 && c <= 4) begin
                check("wrap_pc", smp.wpc, wrap_exp[c - 2]);
            end
        end

        // Backpressure from the start: exactly two requests, buffer holds pc 0 and 4.
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_req", 32'(smp.req), (c < 2) ? 32'd1 : 32'd0);
            if (c < 2) check("bp_addr", smp.addr, 32'(4 * c));
            check("bp_valid", 32'(smp.valid), (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) check("bp_head_pc", smp.pc, 32'd0);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check("bp_resume_valid", 32'(smp.valid), 32'd1);
        end

        // Random backpressure; ordering and content checked by the scoreboard.
        for (int c = 0; c < 40; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        out_ready = 1'b1;
        step();

        // Redirect vectors applied to a running stream.
        for (int i = 0; i < N_VEC; i++) begin
            step();
            step();
            redirect_valid = 1'b1;
            redirect_pc    = vec[i].target;
            step();
            check("redir_req", 32'(smp.req), 32'd0);
            redirect_valid = 1'b0;
            redirect_pc    = 32'h0;
            sb_stream(vec[i].exp_pc);
            step();
            check("redir_gap1", 32'(smp.valid), 32'd0);
            check("redir_req1", 32'(smp.req), 32'd1);
            check("redir_addr1", smp.addr, vec[i].exp_pc);
            step();
            check("redir_gap2", 32'(smp.valid), 32'd0);
            step();
            check("redir_valid", 32'(smp.valid), 32'd1);
            check("redir_pc", smp.pc, vec[i].exp_pc);
            check("redir_pc4", smp.pc4, vec[i].exp_pc4);
            step();
        end

        // Redirect while the buffer is full and the head is taken in the same cycle.
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) step();
        x0             = n_xfer;
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step();
        check("full_redir_valid", 32'(smp.valid), 32'd1);
        check("full_redir_xfer", 32'(n_xfer - x0), 32'd1);
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        sb_stream(32'h0000_0300);
        step();
        check("full_redir_gap1", 32'(smp.valid), 32'd0);
        step();
        check("full_redir_gap2", 32'(smp.valid), 32'd0);
        step();
        check("full_redir_pc", smp.pc, 32'h0000_0300);
        for (int c = 0; c < 3; c++) step();

        // Reset the cycle after a request: the stale response must never surface.
        step();
        check("midrst_req", 32'(smp.req), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        step();
        check("midrst_valid", 32'(smp.valid), 32'd0);
        check("midrst_req_in_reset", 32'(smp.req), 32'd0);
        reset = 1'b0;
        sb_stream(32'h0);
        step();
        check("midrst_gap0", 32'(smp.valid), 32'd0);
        step();
        check("midrst_gap1", 32'(smp.valid), 32'd0);
        step();
        check("midrst_valid2", 32'(smp.valid), 32'd1);
        check("midrst_pc", smp.pc, 32'd0);
        for (int c = 0; c < 3; c++) step();

`ifdef FETCH_ALIGN_CHECK_EN
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exp_q.delete();
        for (int c = 0; c < 5; c++) begin
            step();
            check("mis_flag", 32'(smp.mis), 32'd1);
            check("mis_req", 32'(smp.req), 32'd0);
            check("mis_valid", 32'(smp.valid), 32'd0);
        end
        do_reset();
        step();
        check("mis_cleared", 32'(smp.mis), 32'd0);
        check("mis_req_resumed", 32'(smp.req), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1, instruction-memory read strobe; memory always accepts.
REQ-005 SHALL have port imem_addr, output, 32, read address, valid while imem_req=1.
REQ-006 SHALL have port imem_rdata, input, 32, instruction word, valid exactly one cycle after an accepted imem_req.
REQ-007 SHALL have port redirect_valid, input, 1, branch/jump taken this cycle.
REQ-008 SHALL have port redirect_pc, input, 32, new fetch target.
REQ-009 SHALL have port out_valid, output, 1, instruction available to decode.
REQ-010 SHALL have port out_ready, input, 1, decode accepts; transfer when out_valid and out_ready are both 1.
REQ-011 SHALL have ports out_instr, out_pc and out_pc_plus4, each output, 32: the instruction word, its address, and that address + 4.
REQ-012 SHALL have port misalign, output, 1, present only under FETCH_ALIGN_CHECK_EN.

Function
REQ-013 SHALL hold a 32-bit PC register; each issued request uses imem_addr=PC, then PC <= PC+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-014 SHALL buffer fetched words in a 2-entry FIFO; each entry holds {instr, pc}; out_* SHALL be driven from the FIFO head as registered values.
REQ-015 SHALL assert imem_req only when (FIFO occupancy + outstanding requests) < 2, so that no response is ever dropped for lack of space.
REQ-016 SHALL write each response into the FIFO one cycle after its request, tagged with the PC that was issued.
REQ-017 SHALL permit a FIFO push and pop in the same cycle, including when the FIFO is full.
REQ-018 SHALL, while out_ready=1 continuously, sustain one instruction per cycle after the initial 2-cycle latency.
REQ-019 SHALL, on redirect_valid=1:
- set PC <= redirect_pc;
- flush the FIFO;
- discard the response of any in-flight request;
- suppress imem_req in that cycle.
REQ-020 SHALL treat a transfer (out_valid and out_ready both 1) in the redirect cycle as completed before the flush.
REQ-021 SHALL, after a redirect, hold out_valid=0 for 2 cycles, then present the instruction at redirect_pc.
REQ-022 SHALL give redirect priority over issue, push and pop when they occur in the same cycle.
REQ-023 SHALL compute out_pc_plus4 combinationally from the head entry's pc.

Reset
REQ-024 SHALL, while reset=1, hold:
- PC = RESET_PC;
- FIFO empty, no outstanding request;
- out_valid=0, imem_req=0;
- out_instr, out_pc, out_pc_plus4 at 0;
- misalign=0.
REQ-025 SHALL issue the first request (imem_addr=RESET_PC) in the first cycle after reset deasserts, with out_valid=1 two cycles later.
REQ-026 SHALL abandon any in-flight response when reset asserts mid-operation; that response SHALL NOT appear after reset.

Configuration
REQ-027 SHALL, with FETCH_ALIGN_CHECK_EN defined, on a redirect with redirect_pc[1:0]!=0:
- set misalign=1 (sticky until reset);
- stop issuing requests;
- leave out_valid=0.
REQ-028 SHALL, without FETCH_ALIGN_CHECK_EN, have no misalign port and force redirect_pc[1:0] to 2'b00.

Structure
REQ-029 SHALL place RESET_PC default, the 32-bit word width and the instruction-step constant 4 in a shared package fetch_pkg.
REQ-030 SHALL implement the 2-entry FIFO as sub-module fetch_buffer (push, pop, full, empty, count).

Verification
REQ-031 Reset release, RESET_PC=0, out_ready=1, memory returns addr^32'hA5A5_0000 -> imem_addr 0,4,8,... on consecutive cycles; out_valid from cycle 2; out_pc 0,4,8,...; out_instr 32'hA5A5_0000, 32'hA5A5_0004, ...
REQ-032 out_ready=0 for 5 cycles -> imem_req stops after 2 issues; FIFO holds pc 0 and 4; no loss or duplication on resume.
REQ-033 redirect_valid=1, redirect_pc=32'h0000_0100, mid-stream -> in-flight word discarded; out_valid=0 for 2 cycles; next out_pc=32'h100, out_pc_plus4=32'h104.
REQ-034 RESET_PC=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 With FETCH_ALIGN_CHECK_EN, redirect_pc=32'h0000_0102 -> misalign=1 next cycle; imem_req stays 0 until reset.
REQ-036 Reset asserted the cycle after a request -> out_valid=0 after release until a fresh request to RESET_PC completes.
